// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller for an 8-bit accumulator datapath.
// Owns PC, IR, MAR, MDR and ACC. Talks to memory over a req/ready handshake and
// drives an external combinational ALU.
module instr_sequencer #(
    parameter logic [7:0] RESET_PC      = 8'h00,
    parameter bit         ILLEGAL_HALTS = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    output logic [7:0] acc_out,
    output logic [7:0] pc_out,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_OP,
        S_DECODE,
        S_FETCH_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     r_state;
    logic [7:0] r_pc;
    logic [3:0] r_ir;      // only the opcode nibble is kept; the low nibble is don't-care
    logic [7:0] r_mar;
    logic [7:0] r_mdr;
    logic [7:0] r_acc;
    logic       r_illegal;

    state_t     w_end_state;
    logic       w_acc_zero;

    // Where an instruction goes once it completes: next fetch or idle
    assign w_end_state = run ? S_FETCH_OP : S_IDLE;
    assign w_acc_zero  = (r_acc == 8'h00);

    // Sequencer state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_ir      <= 4'h0;
            r_mar     <= 8'h00;
            r_mdr     <= 8'h00;
            r_acc     <= 8'h00;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH_OP;
                    end
                end
                S_FETCH_OP: begin
                    if (mem_ready) begin
                        r_ir    <= mem_rdata[7:4];
                        r_pc    <= r_pc + 8'd1;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (r_ir)
                        OP_LDA, OP_STA, OP_ADD, OP_SUB,
                        OP_AND, OP_OR, OP_JMP, OP_JZ: r_state <= S_FETCH_ADDR;
                        OP_NOT:                       r_state <= S_EXEC;
                        OP_HLT:                       r_state <= S_HALT;
                        OP_NOP:                       r_state <= w_end_state;
                        default: begin
                            r_illegal <= 1'b1;
                            r_state   <= ILLEGAL_HALTS ? S_HALT : w_end_state;
                        end
                    endcase
                end
                S_FETCH_ADDR: begin
                    if (mem_ready) begin
                        r_mar <= mem_rdata;
                        r_pc  <= r_pc + 8'd1;
                        case (r_ir)
                            OP_STA: r_state <= S_MEM_WR;
                            OP_JMP: begin
                                r_pc    <= mem_rdata;
                                r_state <= w_end_state;
                            end
                            OP_JZ: begin
                                if (w_acc_zero) begin
                                    r_pc <= mem_rdata;
                                end
                                r_state <= w_end_state;
                            end
                            default: r_state <= S_MEM_RD;
                        endcase
                    end
                end
                S_MEM_RD: begin
                    if (mem_ready) begin
                        r_mdr <= mem_rdata;
                        if (r_ir == OP_LDA) begin
                            r_acc   <= mem_rdata;
                            r_state <= w_end_state;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_MEM_WR: begin
                    if (mem_ready) begin
                        r_state <= w_end_state;
                    end
                end
                S_EXEC: begin
                    r_acc   <= alu_result;
                    r_state <= w_end_state;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory port decoded purely from registered state, never from mem_ready
    assign mem_req   = (r_state == S_FETCH_OP) || (r_state == S_FETCH_ADDR) ||
                       (r_state == S_MEM_RD)   || (r_state == S_MEM_WR);
    assign mem_we    = (r_state == S_MEM_WR);
    assign mem_addr  = ((r_state == S_FETCH_OP) || (r_state == S_FETCH_ADDR)) ? r_pc : r_mar;
    assign mem_wdata = r_acc;

    // ALU operands are always presented; the result is only captured in EXEC
    assign alu_op  = r_ir;
    assign alu_a   = r_acc;
    assign alu_b   = r_mdr;

    assign acc_out = r_acc;
    assign pc_out  = r_pc;
    assign halted  = (r_state == S_HALT);
    assign illegal = r_illegal;

endmodule
